// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths and the InvSubBytes FSM encoding
package aes_pkg;
  localparam int AES_STATE_W = 128;
  localparam int AES_NB = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/inv_sbox.sv
// inv_sbox: FIPS-197 inverse S-box lookup, purely combinational
module inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  // Entry 0 sits in the top byte, so entry i ends at bit {~i, 3'b111}
  localparam logic [2047:0] TAB = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
  logic [10:0] w_msb;
  assign w_msb = {~i_byte, 3'b111};
  assign o_byte = TAB[w_msb -: 8];
endmodule

// File: rtl/inverse_sub_bytes.sv
// inverse_sub_bytes: column-serial AES InvSubBytes, one column per cycle,
// valid/ready on both sides with same-cycle handoff from DONE to BUSY.
module inverse_sub_bytes
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] isubout
);
  logic [1:0]             r_state;
  logic [1:0]             r_col;
  logic [AES_STATE_W-1:0] r_data;
  logic [31:0]            w_col;
  logic [31:0]            w_sub;
  logic [6:0]             w_msb;
  logic                   w_accept;
  // Column c occupies bits [127-32c -: 32]; {~c, 5'h1f} is that top bit
  assign w_msb = {~r_col, 5'h1f};
  assign w_col = r_data[w_msb -: 32];
  genvar g;
  for (g = 0; g < AES_NB; g++) begin : g_sbox
    inv_sbox u_sbox (
      .i_byte(w_col[31-8*g -: 8]),
      .o_byte(w_sub[31-8*g -: 8])
    );
  end
  assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign isubout   = out_valid ? r_data : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_col   <= 2'd0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_state <= ST_BUSY;
      r_col   <= 2'd0;
      r_data  <= data_in;
    end else if (r_state == ST_BUSY) begin
      r_data[w_msb -: 32] <= w_sub;
      r_col   <= r_col + 2'd1;
      r_state <= (r_col == 2'd3) ? ST_DONE : ST_BUSY;
    end else if (r_state == ST_DONE && out_ready) begin
      r_state <= ST_IDLE;
    end
  end
endmodule

// File: doc/inverse_sub_bytes.md
INVERSE_SUB_BYTES -- requirements
Module: inverse_sub_bytes

Interface
REQ-001 Ports SHALL be as follows; the block has one clock, and reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 in_valid  input  1  upstream inverse-ShiftRows result on data_in is valid.
REQ-005 in_ready  output  1  block can accept data_in this cycle.
REQ-006 data_in  input  128  AES state, column-major: byte[r,c] at bits [127-8*(4c+r) -: 8].
REQ-007 out_valid  output  1  isubout holds a complete InvSubBytes result.
REQ-008 out_ready  input  1  downstream (AddRoundKey) accepts isubout.
REQ-009 isubout  output  128  InvSubBytes(data_in), same byte layout as data_in.

Function
REQ-010 The block SHALL apply the FIPS-197 inverse S-box to all 16 bytes of the accepted state, processing one column (4 bytes) per cycle.
REQ-011 FSM states SHALL be IDLE, BUSY and DONE.
REQ-012 IDLE: in_ready=1 and out_valid=0.
REQ-013 IDLE: when in_valid is high, the block SHALL capture data_in into the state register, clear col_cnt to 0 and enter BUSY.
REQ-014 BUSY: in_ready=0 and out_valid=0.
REQ-015 BUSY: each cycle, column col_cnt (col 0 = bits [127:96]) SHALL be replaced by its inverse-S-box image, and the other columns SHALL be held.
REQ-016 BUSY: col_cnt (2 bits) SHALL increment each cycle.
REQ-017 BUSY: after column 3 is written, the FSM SHALL enter DONE and col_cnt SHALL wrap to 0.
REQ-018 Latency: with acceptance at edge N, out_valid SHALL be high in the cycle following edge N+4 (4 BUSY cycles).
REQ-019 DONE: out_valid=1 and isubout = state register.
REQ-020 DONE: isubout SHALL be held stable while out_ready=0, for any number of cycles.
REQ-021 DONE with out_ready=1 and in_valid=0: the FSM SHALL go to IDLE.
REQ-022 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready), combinationally.
REQ-023 DONE with out_ready=1 and in_valid=1 (simultaneous handoff and accept): the result is consumed, the new data_in is captured, and the FSM SHALL go directly to BUSY with no bubble.
REQ-024 in_valid SHALL be ignored while BUSY, and while DONE with out_ready=0; no data is captured in those cycles.
REQ-025 isubout SHALL read 128'h0 whenever out_valid=0.
REQ-026 Throughput SHALL be one block per 5 cycles under continuous valid/ready.

Reset
REQ-027 With rst_n=0 at a clk edge, the block SHALL enter IDLE with col_cnt=0 and state register=128'h0.
REQ-028 After reset: out_valid=0, isubout=0 and in_ready=1.
REQ-029 Reset in BUSY or DONE SHALL discard the block in progress, and no partial result SHALL ever appear on isubout.
REQ-030 While rst_n=0, data_in and in_valid SHALL be ignored.

Structure
REQ-031 A shared package aes_pkg SHALL hold AES_STATE_W=128, AES_NB=4 and the FSM state encoding (IDLE/BUSY/DONE, 2 bits).
REQ-032 A combinational sub-module inv_sbox (8-bit in, 8-bit out, 256-entry constant table) SHALL be instantiated 4 times, fed by a column mux on col_cnt.
REQ-033 The block SHALL have no combinational path from data_in to isubout; out_ready->in_ready is the only input-to-output combinational path.

Verification
REQ-034 Bench: data_in=128'h6363...63 with in_valid pulse -> out_valid after 4 BUSY cycles, isubout=128'h0.
REQ-035 Bench: data_in=128'h0, then 128'hFF..FF, back-to-back with out_ready=1 -> isubout=128'h5252..52, then 128'h7D7D..7D; the second block is accepted in the DONE cycle of the first (no IDLE bubble).
REQ-036 Bench: data_in=128'h637C777B_F26B6FC5_3001672B_FED7AB76 -> isubout=128'h00010203_04050607_08090A0B_0C0D0E0F.
REQ-037 Bench: DONE with out_ready=0 for 7 cycles while in_valid=1 with changing data -> isubout is stable, in_ready=0, and the first result is delivered unchanged when out_ready rises.
REQ-038 Bench: rst_n=0 during the 2nd BUSY cycle -> next cycle in IDLE, out_valid=0, isubout=0; a new block of all 0x16 then yields all 0xFF.
REQ-039 Bench: random 1000-block run against a reference-model InvSubBytes with random valid/ready stalls -> zero mismatches, no dropped or duplicated blocks.
